// File: rtl/queue_wr_arbiter.sv
// queue_wr_arbiter: packet-locked arbiter sharing one ram_queue write port between NUM_REQ producers.
// Optional QARB_FIXED_PRIO_EN selects fixed priority (requester 0 highest) instead of round-robin.
module queue_wr_arbiter #(
   parameter  int NUM_REQ    = 4,
   parameter  int DATA_WIDTH = 4,
   localparam int IDX_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   input  logic [NUM_REQ-1:0]            req_last_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   output logic                          q_wvalid_o,
   output logic [DATA_WIDTH-1:0]         q_wdata_o,
   input  logic                          q_full_i,
   output logic [IDX_WIDTH-1:0]          grant_idx_o,
   output logic                          busy_o
);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_t;

   state_t               state_r;
   logic [IDX_WIDTH-1:0] owner_r;
   logic [IDX_WIDTH-1:0] base_s;
   logic [IDX_WIDTH-1:0] idle_win_s;
   logic                 idle_found_s;
   logic [IDX_WIDTH-1:0] win_s;
   logic                 win_exists_s;
   logic                 win_valid_s;
   logic                 win_last_s;
   logic                 xfer_s;

`ifdef QARB_FIXED_PRIO_EN
   assign base_s = '0;
`else
   logic [IDX_WIDTH-1:0] rr_ptr_r;
   logic [IDX_WIDTH-1:0] next_ptr_s;

   assign base_s     = rr_ptr_r;
   assign next_ptr_s = (win_s == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : win_s + IDX_WIDTH'(1);
`endif

   function automatic logic bit_at(input logic [NUM_REQ-1:0] vec, input int idx);
      logic r;
      r = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         r = r | (vec[k] & (k == idx));
      end
      return r;
   endfunction

   // First valid requester at or after base_s, wrapping past NUM_REQ-1.
   always_comb begin
      int   cand;
      logic hit;
      idle_found_s = 1'b0;
      idle_win_s   = '0;
      cand         = 0;
      hit          = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand         = int'(base_s) + i;
         cand         = (cand >= NUM_REQ) ? cand - NUM_REQ : cand;
         hit          = ~idle_found_s & bit_at(req_valid_i, cand);
         idle_win_s   = hit ? IDX_WIDTH'(cand) : idle_win_s;
         idle_found_s = idle_found_s | hit;
      end
   end

   assign win_s        = (state_r == ST_LOCKED) ? owner_r : idle_win_s;
   assign win_exists_s = (state_r == ST_LOCKED) | idle_found_s;
   assign win_valid_s  = bit_at(req_valid_i, int'(win_s));
   assign win_last_s   = bit_at(req_last_i, int'(win_s));
   assign xfer_s       = reset_n & win_exists_s & win_valid_s & ~q_full_i;

   // Route the winner's beat straight to the queue; everything is zero without a transfer.
   always_comb begin
      logic sel;
      sel         = 1'b0;
      req_ready_o = '0;
      q_wdata_o   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sel            = xfer_s & (win_s == IDX_WIDTH'(k));
         req_ready_o[k] = sel;
         q_wdata_o      = q_wdata_o | (sel ? req_data_i[k*DATA_WIDTH +: DATA_WIDTH] : '0);
      end
   end

   assign q_wvalid_o  = xfer_s;
   assign busy_o      = reset_n & (state_r == ST_LOCKED);
   assign grant_idx_o = !reset_n                ? '0 :
                        (state_r == ST_LOCKED)  ? owner_r :
                        idle_found_s            ? idle_win_s : base_s;

   // Lock on a non-final beat; release and advance the pointer once the final beat transfers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r  <= ST_IDLE;
         owner_r  <= '0;
`ifndef QARB_FIXED_PRIO_EN
         rr_ptr_r <= '0;
`endif
      end else if (xfer_s) begin
         case (state_r)
            ST_IDLE: begin
               if (win_last_s) begin
`ifndef QARB_FIXED_PRIO_EN
                  rr_ptr_r <= next_ptr_s;
`endif
               end else begin
                  state_r <= ST_LOCKED;
                  owner_r <= win_s;
               end
            end
            ST_LOCKED: begin
               if (win_last_s) begin
                  state_r  <= ST_IDLE;
`ifndef QARB_FIXED_PRIO_EN
                  rr_ptr_r <= next_ptr_s;
`endif
               end
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_queue_wr_arbiter.sv
// Self-checking bench for queue_wr_arbiter: directed scenarios plus randomized traffic vs. a packet-level model.
module tb_queue_wr_arbiter;
   localparam int N  = 4;
   localparam int DW = 4;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [N-1:0]    req_valid, req_last, req_ready;
   logic [N*DW-1:0] req_data;
   logic            q_wvalid, q_full, busy;
   logic [DW-1:0]   q_wdata;
   logic [IW-1:0]   grant_idx;

   queue_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid_i(req_valid), .req_last_i(req_last), .req_data_i(req_data),
      .req_ready_o(req_ready), .q_wvalid_o(q_wvalid), .q_wdata_o(q_wdata),
      .q_full_i(q_full), .grant_idx_o(grant_idx), .busy_o(busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // packet-level reference state
   bit m_locked;
   int m_ptr, m_own;
   // expected values for the current input set
   logic [N-1:0]  e_ready;
   logic          e_wv, e_busy;
   logic [DW-1:0] e_wd;
   int            e_grant, e_win;
   bit            e_xfer;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      m_locked = 1'b0;
      m_ptr    = 0;
      m_own    = 0;
   endfunction

   function automatic void model_eval();
      bit found;
      int base;
      found = 1'b0;
      e_win = 0;
`ifdef QARB_FIXED_PRIO_EN
      base = 0;
`else
      base = m_ptr;
`endif
      if (m_locked) begin
         found = 1'b1;
         e_win = m_own;
      end else begin
         for (int i = 0; i < N; i++) begin
            int k;
            k = (base + i) % N;
            if (!found && req_valid[k]) begin
               found = 1'b1;
               e_win = k;
            end
         end
      end
      e_xfer  = reset_n && found && req_valid[e_win] && !q_full;
      e_ready = e_xfer ? N'(1 << e_win) : '0;
      e_wv    = e_xfer;
      e_wd    = e_xfer ? DW'(req_data >> (e_win * DW)) : '0;
      e_busy  = reset_n && m_locked;
      e_grant = !reset_n ? 0 : (m_locked ? m_own : (found ? e_win : base));
   endfunction

   function automatic void model_update();
      if (e_xfer) begin
         if (!m_locked) begin
            if (req_last[e_win]) m_ptr = (e_win + 1) % N;
            else begin
               m_locked = 1'b1;
               m_own    = e_win;
            end
         end else if (req_last[e_win]) begin
            m_locked = 1'b0;
            m_ptr    = (m_own + 1) % N;
         end
      end
   endfunction

   task automatic check_outputs(input string tag);
      model_eval();
      check_val({tag, ".ready"}, 32'(req_ready), 32'(e_ready));
      check_val({tag, ".wvalid"}, 32'(q_wvalid), 32'(e_wv));
      check_val({tag, ".wdata"}, 32'(q_wdata), 32'(e_wd));
      check_val({tag, ".grant"}, 32'(grant_idx), 32'(e_grant));
      check_val({tag, ".busy"}, 32'(busy), 32'(e_busy));
   endtask

   task automatic run_cycle(input string tag);
      @(negedge clk);
      check_outputs(tag);
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic set_req(input int k, input bit v, input bit l, input logic [DW-1:0] d);
      req_valid[k]          = v;
      req_last[k]           = l;
      req_data[k*DW +: DW]  = d;
   endtask

   task automatic do_reset();
      #1 reset_n = 1'b0;
      model_reset();
      #1 reset_n = 1'b1;
   endtask

   initial begin
      logic [DW-1:0] rr_exp   [4] = '{4'h1, 4'h2, 4'h3, 4'h1};
      logic [DW-1:0] lock_dat [3] = '{4'hA, 4'hB, 4'hC};
      logic          lock_bsy [3] = '{1'b0, 1'b1, 1'b1};

      reset_n   = 1'b0;
      model_reset();
      req_valid = '1;
      req_last  = '1;
      req_data  = 16'h4321;
      q_full    = 1'b0;

      // all outputs low while reset is held, whatever the inputs
      #3;
      check_outputs("reset");
      check_val("reset_wvalid", 32'(q_wvalid), 32'd0);
      check_val("reset_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      #1;
      check_val("first_grant", 32'(grant_idx), 32'd0);
      check_val("first_ready", 32'(req_ready), 32'b0001);
      run_cycle("first");

`ifndef QARB_FIXED_PRIO_EN
      // round-robin among single-beat packets
      do_reset();
      set_req(0, 1'b1, 1'b1, 4'h1);
      set_req(1, 1'b1, 1'b1, 4'h2);
      set_req(2, 1'b1, 1'b1, 4'h3);
      set_req(3, 1'b0, 1'b0, 4'h0);
      for (int i = 0; i < 4; i++) begin
         #1;
         check_val("rr_data", 32'(q_wdata), 32'(rr_exp[i]));
         check_val("rr_busy", 32'(busy), 32'd0);
         run_cycle("rr");
      end

      // requester 1 holds the port for a 3-beat packet while 0 and 2 wait
      for (int i = 0; i < 3; i++) begin
         set_req(1, 1'b1, (i == 2), lock_dat[i]);
         #1;
         check_val("lock_data", 32'(q_wdata), 32'(lock_dat[i]));
         check_val("lock_ready", 32'(req_ready), 32'b0010);
         check_val("lock_busy", 32'(busy), 32'(lock_bsy[i]));
         run_cycle("lock");
      end
      set_req(1, 1'b0, 1'b0, 4'h0);
      #1;
      check_val("lock_next_ready", 32'(req_ready), 32'b0100);
      run_cycle("lock_next");

      // backpressure in the middle of requester 3's packet
      set_req(3, 1'b1, 1'b0, 4'hD);
      #1;
      check_val("bp_b1_ready", 32'(req_ready), 32'b1000);
      run_cycle("bp_b1");
      set_req(3, 1'b1, 1'b0, 4'hE);
      q_full = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         check_val("bp_full_wvalid", 32'(q_wvalid), 32'd0);
         check_val("bp_full_ready", 32'(req_ready), 32'd0);
         check_val("bp_full_busy", 32'(busy), 32'd1);
         run_cycle("bp_full");
      end
      q_full = 1'b0;
      #1;
      check_val("bp_b2_data", 32'(q_wdata), 32'hE);
      run_cycle("bp_b2");
      set_req(3, 1'b1, 1'b1, 4'hF);
      #1;
      check_val("bp_b3_data", 32'(q_wdata), 32'hF);
      run_cycle("bp_b3");
      set_req(3, 1'b0, 1'b0, 4'h0);

      // asynchronous reset while locked
      set_req(0, 1'b1, 1'b0, 4'h5);
      run_cycle("arst_b1");
      set_req(0, 1'b1, 1'b0, 4'h6);
      #1;
      check_val("arst_pre_busy", 32'(busy), 32'd1);
      check_val("arst_pre_wvalid", 32'(q_wvalid), 32'd1);
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      check_val("arst_busy", 32'(busy), 32'd0);
      check_val("arst_wvalid", 32'(q_wvalid), 32'd0);
      check_outputs("arst_mid");
      @(posedge clk);
      #1 reset_n = 1'b1;
      set_req(1, 1'b0, 1'b1, 4'h0);
      set_req(3, 1'b1, 1'b1, 4'h7);
      #1;
      check_val("arst_after_grant", 32'(grant_idx), 32'd0);
      check_val("arst_after_ready", 32'(req_ready), 32'b0001);
      run_cycle("arst_after");
`else
      // fixed priority: requester 0 always beats requester 3
      do_reset();
      req_valid = '0;
      set_req(0, 1'b1, 1'b1, 4'h1);
      set_req(3, 1'b1, 1'b1, 4'h9);
      for (int i = 0; i < 6; i++) begin
         #1;
         check_val("fp_ready", 32'(req_ready), 32'b0001);
         check_val("fp_ready3", 32'(req_ready[3]), 32'd0);
         run_cycle("fp");
      end
`endif

      // randomized traffic; producers hold a beat until it is accepted
      for (int c = 0; c < 400; c++) begin
         q_full = ($urandom_range(0, 3) == 0);
         for (int k = 0; k < N; k++) begin
            if (!req_valid[k] && $urandom_range(0, 1) == 1)
               set_req(k, 1'b1, ($urandom_range(0, 4) < 2), DW'($urandom));
         end
         run_cycle("rand");
         for (int k = 0; k < N; k++) begin
            if (e_ready[k])
               set_req(k, ($urandom_range(0, 1) == 1), ($urandom_range(0, 4) < 2), DW'($urandom));
         end
         if ($urandom_range(0, 49) == 0) begin
            #1 reset_n = 1'b0;
            model_reset();
            #1;
            check_outputs("rand_rst");
            reset_n = 1'b1;
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
